// File: rtl/key_pkg.sv
// Shared constants for the debounced key counter: default timing at a 50 MHz clock,
// arithmetic mode encodings, the update operation type and a counter-width helper.
package key_pkg;

    localparam int DEF_DEB_CYCLES   = 50_000;      // 1 ms
    localparam int DEF_REPEAT_DELAY = 25_000_000;  // 0.5 s
    localparam int DEF_REPEAT_RATE  = 5_000_000;   // 0.1 s

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLR,
        OP_INC,
        OP_DEC
    } op_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_updown_counter_if.sv
// Board-side bundle of the counter: three active-low keys in, LED bank and limit flags out.
interface key_updown_counter_if #(
    parameter int WIDTH = 10
);
    logic             KEY_CLR;
    logic             KEY_INC;
    logic             KEY_DEC;
    logic [WIDTH-1:0] LEDG;
    logic             at_max;
    logic             at_min;

    modport master (output KEY_CLR, KEY_INC, KEY_DEC, input LEDG, at_max, at_min);
    modport slave  (input KEY_CLR, KEY_INC, KEY_DEC, output LEDG, at_max, at_min);
endinterface

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchroniser, debounce filter on the accepted level,
// and a one-cycle press pulse with optional auto-repeat while the key stays held.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press,
    output logic level
);

    localparam int DEB_W     = cnt_width(DEB_CYCLES);
    localparam int REP_MAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W     = cnt_width(REP_MAX);
    localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REP_W-1:0] FIRST_LAST = REP_W'(REPEAT_EN ? REPEAT_DELAY - 1 : 0);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic [1:0]       sync_q, sync_d;
    logic             lvl_q, lvl_d;
    logic             lvl_prev_q, lvl_prev_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             first_q, first_d;
    logic             press_q, press_d;
    logic             fall, held, fire;

    // NOTE: every variable gets its default before any branch, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        sync_d     = {sync_q[0], key_n};
        lvl_d      = lvl_q;
        deb_cnt_d  = '0;
        lvl_prev_d = lvl_q;

        // The counter only survives consecutive cycles of disagreement.
        if (sync_q[1] != lvl_q) begin
            if (deb_cnt_q == DEB_LAST) lvl_d = ~lvl_q;
            else                       deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end

        fall = lvl_prev_q & ~lvl_q;
        held = ~lvl_q;
        fire = REPEAT_EN && held && !fall &&
               (rep_cnt_q == (first_q ? FIRST_LAST : RATE_LAST));

        press_d   = fall | fire;
        first_d   = first_q;
        rep_cnt_d = '0;
        if (fall)      first_d = 1'b1;
        else if (fire) first_d = 1'b0;
        // rep_cnt_q holds cycles elapsed since the most recent pulse.
        if (REPEAT_EN && held && !press_d) rep_cnt_d = rep_cnt_q + REP_W'(1);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values and simulation matches the synthesised registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            lvl_q      <= 1'b1;
            lvl_prev_q <= 1'b1;
            deb_cnt_q  <= '0;
            rep_cnt_q  <= '0;
            first_q    <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_prev_d;
            deb_cnt_q  <= deb_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            first_q    <= first_d;
            press_q    <= press_d;
        end
    end

    assign press = press_q;
    assign level = lvl_q;

endmodule

// File: rtl/key_updown_counter.sv
// Debounced up/down counter between the board keys and the LED bank, with
// configurable step and either wrap-around or saturating arithmetic.
module key_updown_counter
    import key_pkg::*;
#(
    parameter int          WIDTH        = 10,
    parameter int unsigned STEP         = 1,
    parameter int          SATURATE     = MODE_WRAP,
    parameter int          DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int          REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int          REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             KEY_CLR,
    input  logic             KEY_INC,
    input  logic             KEY_DEC,
    output logic [WIDTH-1:0] LEDG,
    output logic             at_max,
    output logic             at_min
);

    typedef logic [WIDTH:0] ext_t;

    logic             clr_p, inc_p, dec_p;
    logic [WIDTH-1:0] count_q, count_d;
    ext_t             sum, diff;
    op_e              op;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) u_clr (.clk(clk), .rst_n(rst_n), .key_n(KEY_CLR), .press(clr_p), .level());

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) u_inc (.clk(clk), .rst_n(rst_n), .key_n(KEY_INC), .press(inc_p), .level());

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) u_dec (.clk(clk), .rst_n(rst_n), .key_n(KEY_DEC), .press(dec_p), .level());

    always_comb begin
        op = OP_HOLD;
        if (clr_p)               op = OP_CLR;
        else if (inc_p && !dec_p) op = OP_INC;
        else if (dec_p && !inc_p) op = OP_DEC;
    end

    // The extra top bit of the WIDTH+1 result flags carry out or borrow.
    always_comb begin
        sum     = {1'b0, count_q} + ext_t'(STEP);
        diff    = {1'b0, count_q} - ext_t'(STEP);
        count_d = count_q;
        case (op)
            OP_CLR:  count_d = '0;
            OP_INC:  count_d = (SATURATE == MODE_SAT && sum[WIDTH])  ? '1 : sum[WIDTH-1:0];
            OP_DEC:  count_d = (SATURATE == MODE_SAT && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign LEDG   = count_q;
    assign at_max = &count_q;
    assign at_min = ~|count_q;

endmodule

// File: tb/tb_key_updown_counter.sv
// Directed bench: three counters share the keys (step 1 wrap, step 3 wrap, step 1
// saturate) and each scenario checks hand-computed LED values at exact cycles.
module tb_key_updown_counter;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    key_updown_counter_if #(.WIDTH(W)) kif ();

    logic [W-1:0] ledg_w, ledg_s;
    logic         at_max_w, at_min_w, at_max_s, at_min_s;

    always #5 clk = ~clk;

    key_updown_counter #(
        .WIDTH(W), .STEP(1), .SATURATE(0),
        .DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)
    ) u_std (
        .clk(clk), .rst_n(rst_n),
        .KEY_CLR(kif.KEY_CLR), .KEY_INC(kif.KEY_INC), .KEY_DEC(kif.KEY_DEC),
        .LEDG(kif.LEDG), .at_max(kif.at_max), .at_min(kif.at_min)
    );

    key_updown_counter #(
        .WIDTH(W), .STEP(3), .SATURATE(0),
        .DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .KEY_CLR(kif.KEY_CLR), .KEY_INC(kif.KEY_INC), .KEY_DEC(kif.KEY_DEC),
        .LEDG(ledg_w), .at_max(at_max_w), .at_min(at_min_w)
    );

    key_updown_counter #(
        .WIDTH(W), .STEP(1), .SATURATE(1),
        .DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)
    ) u_sat (
        .clk(clk), .rst_n(rst_n),
        .KEY_CLR(kif.KEY_CLR), .KEY_INC(kif.KEY_INC), .KEY_DEC(kif.KEY_DEC),
        .LEDG(ledg_s), .at_max(at_max_s), .at_min(at_min_s)
    );

    // Advance n rising edges, then step 1 ns past the edge for driving and sampling.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic clr_n, input logic inc_n, input logic dec_n);
        kif.KEY_CLR = clr_n;
        kif.KEY_INC = inc_n;
        kif.KEY_DEC = dec_n;
    endtask

    task automatic do_reset();
        set_keys(1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
    endtask

    // Clean press long enough to be accepted, short enough not to auto-repeat.
    task automatic press_keys(input logic clr_n, input logic inc_n, input logic dec_n);
        set_keys(clr_n, inc_n, dec_n);
        cyc(10);
        set_keys(1'b1, 1'b1, 1'b1);
        cyc(10);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (kif.LEDG !== 4'd0) begin
            n_fail++; $display("FAIL reset_ledg: got %0d expected 0", kif.LEDG);
        end
        n_tests++;
        if (kif.at_min !== 1'b1 || kif.at_max !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got min=%b max=%b expected min=1 max=0", kif.at_min, kif.at_max);
        end
        n_tests++;
        if (ledg_w !== 4'd0 || at_min_w !== 1'b1 || ledg_s !== 4'd0 || at_max_s !== 1'b0) begin
            n_fail++; $display("FAIL reset_others: got w=%0d minw=%b s=%0d maxs=%b expected 0 1 0 0", ledg_w, at_min_w, ledg_s, at_max_s);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_keys(1'b1, 1'b0, 1'b1);
            cyc(3);
            set_keys(1'b1, 1'b1, 1'b1);
            cyc(5);
        end
        cyc(10);
        n_tests++;
        if (kif.LEDG !== 4'd0) begin
            n_fail++; $display("FAIL bounce_reject: got %0d expected 0", kif.LEDG);
        end
        set_keys(1'b1, 1'b0, 1'b1);
        cyc(7);
        n_tests++;
        if (kif.LEDG !== 4'd0) begin
            n_fail++; $display("FAIL bounce_early: got %0d expected 0 at 7 cycles", kif.LEDG);
        end
        cyc(1);
        n_tests++;
        if (kif.LEDG !== 4'd1) begin
            n_fail++; $display("FAIL bounce_latency: got %0d expected 1 at 8 cycles", kif.LEDG);
        end
        set_keys(1'b1, 1'b1, 1'b1);
        cyc(10);
        n_tests++;
        if (kif.LEDG !== 4'd1) begin
            n_fail++; $display("FAIL bounce_release: got %0d expected 1", kif.LEDG);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) press_keys(1'b1, 1'b0, 1'b1);
        n_tests++;
        if (ledg_w !== 4'd15 || at_max_w !== 1'b1 || at_min_w !== 1'b0) begin
            n_fail++; $display("FAIL wrap_15: got %0d max=%b min=%b expected 15 1 0", ledg_w, at_max_w, at_min_w);
        end
        for (int i = 0; i < 5; i++) press_keys(1'b1, 1'b0, 1'b1);
        n_tests++;
        if (ledg_w !== 4'd14 || at_max_w !== 1'b0 || at_min_w !== 1'b0) begin
            n_fail++; $display("FAIL wrap_14: got %0d max=%b min=%b expected 14 0 0", ledg_w, at_max_w, at_min_w);
        end
        press_keys(1'b1, 1'b0, 1'b1);
        n_tests++;
        if (ledg_w !== 4'd1) begin
            n_fail++; $display("FAIL wrap_overflow: got %0d expected 1", ledg_w);
        end
        press_keys(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (ledg_w !== 4'd14) begin
            n_fail++; $display("FAIL wrap_underflow: got %0d expected 14", ledg_w);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 16; i++) press_keys(1'b1, 1'b0, 1'b1);
        n_tests++;
        if (ledg_s !== 4'd15 || at_max_s !== 1'b1) begin
            n_fail++; $display("FAIL sat_top: got %0d max=%b expected 15 1", ledg_s, at_max_s);
        end
        press_keys(1'b1, 1'b0, 1'b1);
        n_tests++;
        if (ledg_s !== 4'd15) begin
            n_fail++; $display("FAIL sat_clamp_hi: got %0d expected 15", ledg_s);
        end
        for (int i = 0; i < 16; i++) press_keys(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (ledg_s !== 4'd0 || at_min_s !== 1'b1) begin
            n_fail++; $display("FAIL sat_bottom: got %0d min=%b expected 0 1", ledg_s, at_min_s);
        end
        press_keys(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (ledg_s !== 4'd0) begin
            n_fail++; $display("FAIL sat_clamp_lo: got %0d expected 0", ledg_s);
        end
    endtask

    task automatic test_auto_repeat();
        do_reset();
        // Pin low at cycle 0: accepted at 6, press at 7, repeats at 27, 32, ... 62.
        set_keys(1'b1, 1'b0, 1'b1);
        cyc(8);
        n_tests++;
        if (kif.LEDG !== 4'd1) begin
            n_fail++; $display("FAIL rep_press: got %0d expected 1", kif.LEDG);
        end
        cyc(19);
        n_tests++;
        if (kif.LEDG !== 4'd1) begin
            n_fail++; $display("FAIL rep_delay_early: got %0d expected 1 at cycle 27", kif.LEDG);
        end
        cyc(1);
        n_tests++;
        if (kif.LEDG !== 4'd2) begin
            n_fail++; $display("FAIL rep_first: got %0d expected 2 at cycle 28", kif.LEDG);
        end
        cyc(4);
        n_tests++;
        if (kif.LEDG !== 4'd2) begin
            n_fail++; $display("FAIL rep_rate_early: got %0d expected 2 at cycle 32", kif.LEDG);
        end
        cyc(1);
        n_tests++;
        if (kif.LEDG !== 4'd3) begin
            n_fail++; $display("FAIL rep_second: got %0d expected 3 at cycle 33", kif.LEDG);
        end
        cyc(27);
        n_tests++;
        if (kif.LEDG !== 4'd8) begin
            n_fail++; $display("FAIL rep_cycle60: got %0d expected 8", kif.LEDG);
        end
        set_keys(1'b1, 1'b1, 1'b1);
        cyc(3);
        n_tests++;
        if (kif.LEDG !== 4'd9) begin
            n_fail++; $display("FAIL rep_total: got %0d expected 9", kif.LEDG);
        end
        cyc(30);
        n_tests++;
        if (kif.LEDG !== 4'd9) begin
            n_fail++; $display("FAIL rep_halt: got %0d expected 9 after release", kif.LEDG);
        end
    endtask

    task automatic test_priority();
        do_reset();
        press_keys(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (kif.LEDG !== 4'd0 || ledg_w !== 4'd0 || ledg_s !== 4'd0) begin
            n_fail++; $display("FAIL prio_inc_dec: got %0d/%0d/%0d expected 0/0/0", kif.LEDG, ledg_w, ledg_s);
        end
        for (int i = 0; i < 7; i++) press_keys(1'b1, 1'b0, 1'b1);
        n_tests++;
        if (kif.LEDG !== 4'd7) begin
            n_fail++; $display("FAIL prio_preload: got %0d expected 7", kif.LEDG);
        end
        set_keys(1'b0, 1'b0, 1'b1);
        cyc(7);
        n_tests++;
        if (kif.LEDG !== 4'd7) begin
            n_fail++; $display("FAIL prio_clr_early: got %0d expected 7", kif.LEDG);
        end
        cyc(1);
        n_tests++;
        if (kif.LEDG !== 4'd0 || kif.at_min !== 1'b1) begin
            n_fail++; $display("FAIL prio_clr_inc: got %0d min=%b expected 0 1", kif.LEDG, kif.at_min);
        end
        set_keys(1'b1, 1'b1, 1'b1);
        cyc(10);
        n_tests++;
        if (kif.LEDG !== 4'd0) begin
            n_fail++; $display("FAIL prio_clr_hold: got %0d expected 0", kif.LEDG);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        for (int i = 0; i < 5; i++) press_keys(1'b1, 1'b0, 1'b1);
        set_keys(1'b1, 1'b1, 1'b0);
        cyc(4);
        n_tests++;
        if (kif.LEDG !== 4'd5) begin
            n_fail++; $display("FAIL mid_preload: got %0d expected 5", kif.LEDG);
        end
        rst_n = 1'b0;
        cyc(2);
        n_tests++;
        if (kif.LEDG !== 4'd0 || kif.at_min !== 1'b1) begin
            n_fail++; $display("FAIL mid_in_reset: got %0d min=%b expected 0 1", kif.LEDG, kif.at_min);
        end
        rst_n = 1'b1;
        cyc(7);
        n_tests++;
        if (kif.LEDG !== 4'd0) begin
            n_fail++; $display("FAIL mid_early: got %0d expected 0 at 7 cycles", kif.LEDG);
        end
        cyc(1);
        n_tests++;
        if (kif.LEDG !== 4'd15) begin
            n_fail++; $display("FAIL mid_reaccept: got %0d expected 15 at 8 cycles", kif.LEDG);
        end
        set_keys(1'b1, 1'b1, 1'b1);
        cyc(10);
        n_tests++;
        if (kif.LEDG !== 4'd15) begin
            n_fail++; $display("FAIL mid_single: got %0d expected 15", kif.LEDG);
        end
    endtask

    initial begin
        set_keys(1'b1, 1'b1, 1'b1);
        test_reset();
        test_bounce();
        test_wrap();
        test_saturate();
        test_auto_repeat();
        test_priority();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
